// File: rtl/ksa_shuffle.sv
// ----------------------------------------------------------------------------
// ksa_shuffle
//
// RC4 key-scheduling stage. Once the init stage has filled S with S[i]=i, this
// block walks i from 0 to 2**ADDR_W-1. For each i it reads S[i], advances
// j by S[i] plus one key byte, reads S[j], and then writes the two values
// back swapped. Every S access goes through a start/finish request handshake
// with the S memory interface.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   start_ksa           level start (from the init stage's finish_init)
//   finish_ksa          high while the shuffle is complete, until start_ksa drops
//   secret_key          key, byte 0 in the MSBs; captured when a run starts
//   address             S address for the current access
//   data_out            S write data
//   data_in             S read data, valid when finish_readWrite_op=1
//   readWrite           0 = read, 1 = write
//   start_readWrite_op  access request
//   finish_readWrite_op access complete (may be tied high)
// ----------------------------------------------------------------------------
module ksa_shuffle #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_ksa,
  output logic                   finish_ksa,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      address,
  output logic [ADDR_W-1:0]      data_out,
  input  logic [ADDR_W-1:0]      data_in,
  output logic                   readWrite,
  output logic                   start_readWrite_op,
  input  logic                   finish_readWrite_op
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    RD_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [ADDR_W-1:0]        i_reg, i_next;
  logic [ADDR_W-1:0]        j_reg, j_next;
  logic [KW-1:0]            k_reg, k_next;      // i mod KEY_BYTES
  logic [ADDR_W-1:0]        si_reg, si_next;
  logic [ADDR_W-1:0]        sj_reg, sj_next;
  logic [8*KEY_BYTES-1:0]   key_reg, key_next;

  // Split the latched key into bytes; byte 0 sits in the most significant bits.
  logic [7:0] key_bytes [KEY_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key_bytes
      assign key_bytes[gi] = key_reg[8*KEY_BYTES-1-8*gi -: 8];
    end
  endgenerate

  // Key byte reduced to S width; only the low ADDR_W bits matter modulo 2**ADDR_W.
  logic [ADDR_W-1:0] key_term;
  logic [ADDR_W-1:0] j_sum;

  assign key_term = ADDR_W'(key_bytes[k_reg]);
  assign j_sum    = j_reg + data_in + key_term;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      si_reg    <= '0;
      sj_reg    <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      key_reg   <= key_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    key_next   = key_reg;

    unique case (state_reg)
      IDLE: begin
        if (start_ksa) begin
          key_next   = secret_key;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          state_next = RD_I;
        end
      end

      RD_I: begin
        if (finish_readWrite_op) begin
          si_next    = data_in;
          j_next     = j_sum;
          state_next = RD_J;
        end
      end

      RD_J: begin
        if (finish_readWrite_op) begin
          sj_next    = data_in;
          state_next = WR_I;
        end
      end

      WR_I: begin
        if (finish_readWrite_op) begin
          state_next = WR_J;
        end
      end

      WR_J: begin
        if (finish_readWrite_op) begin
          if (i_reg == I_LAST) begin
            state_next = DONE;
          end else begin
            i_next     = i_reg + ADDR_W'(1);
            k_next     = (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
            state_next = RD_I;
          end
        end
      end

      DONE: begin
        // Completion is level-held; only a dropped start re-arms the block.
        if (!start_ksa) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they are stable across
  // memory stalls and clear the moment reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    address            = '0;
    data_out           = '0;
    readWrite          = 1'b0;
    start_readWrite_op = 1'b0;
    finish_ksa         = 1'b0;

    unique case (state_reg)
      RD_I: begin
        address            = i_reg;
        start_readWrite_op = 1'b1;
      end
      RD_J: begin
        address            = j_reg;
        start_readWrite_op = 1'b1;
      end
      WR_I: begin
        address            = i_reg;
        data_out           = sj_reg;
        readWrite          = 1'b1;
        start_readWrite_op = 1'b1;
      end
      WR_J: begin
        address            = j_reg;
        data_out           = si_reg;
        readWrite          = 1'b1;
        start_readWrite_op = 1'b1;
      end
      DONE: begin
        finish_ksa = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// ----------------------------------------------------------------------------
// tb_ksa_shuffle
//
// Bench for ksa_shuffle. A behavioural S memory answers the DUT's access
// handshake (optionally stalling each access for 3 cycles). Before each run a
// software KSA model fills a queue with the expected access stream; a monitor
// pops and compares every completed access. Final S contents, latency,
// reset behaviour and the DONE hand-off are checked by the stimulus process.
// ----------------------------------------------------------------------------
module tb_ksa_shuffle;

  localparam int KB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_ksa;
  logic          finish_ksa;
  logic [23:0]   secret_key;
  logic [7:0]    address;
  logic [7:0]    data_out;
  logic [7:0]    data_in;
  logic          readWrite;
  logic          start_op;
  logic          finish_op;

  ksa_shuffle #(.KEY_BYTES(KB), .ADDR_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_ksa           (start_ksa),
    .finish_ksa          (finish_ksa),
    .secret_key          (secret_key),
    .address             (address),
    .data_out            (data_out),
    .data_in             (data_in),
    .readWrite           (readWrite),
    .start_readWrite_op  (start_op),
    .finish_readWrite_op (finish_op)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- S memory
  logic [7:0] s_mem [256];
  logic       init_req = 1'b0;
  bit         stall_mode = 1'b0;
  int         stall_cnt = 0;

  assign data_in   = s_mem[address];
  assign finish_op = stall_mode ? (stall_cnt == 3) : 1'b1;

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) s_mem[k] <= 8'(k);
    end else if (start_op && finish_op && readWrite) begin
      s_mem[address] <= data_out;
    end
    if (!start_op || finish_op) stall_cnt <= 0;
    else                        stall_cnt <= stall_cnt + 1;
  end

  // ------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int log_q[$];
  int model_s [256];
  int stall_viol = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int pack(input int rw, input int a, input int d);
    return (rw << 16) | (a << 8) | d;
  endfunction

  function automatic int key_byte(input logic [23:0] key, input int k);
    return int'((key >> (8 * (KB - 1 - k))) & 24'hFF);
  endfunction

  // Plain software RC4 key schedule, recording the four accesses per step.
  task automatic build_model(input logic [23:0] key);
    int s [256];
    int j;
    int si;
    int sj;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j  = (j + s[i] + key_byte(key, i % KB)) % 256;
      si = s[i];
      sj = s[j];
      exp_q.push_back(pack(0, i, 0));
      exp_q.push_back(pack(0, j, 0));
      exp_q.push_back(pack(1, i, sj));
      exp_q.push_back(pack(1, j, si));
      s[i] = sj;
      s[j] = si;
    end
    for (int k = 0; k < 256; k++) model_s[k] = s[k];
  endtask

  // ----------------------------------------------------------------- monitor
  logic        stall_prev = 1'b0;
  logic [16:0] hold_val   = '0;

  always @(negedge clk) begin
    int act;
    int e;
    if (stall_prev && start_op && ({readWrite, address, data_out} != hold_val))
      stall_viol++;
    stall_prev <= start_op && !finish_op;
    hold_val   <= {readWrite, address, data_out};
    if (start_op && finish_op) begin
      act = readWrite ? pack(1, int'(address), int'(data_out))
                      : pack(0, int'(address), 0);
      log_q.push_back(act);
      if (exp_q.size() == 0) begin
        check("unexpected_access", act, -1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("access_%0d", log_q.size() - 1), act, e);
      end
    end
  end

  // ------------------------------------------------------------------- tasks
  task automatic prep(input logic [23:0] key);
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
    exp_q.delete();
    log_q.delete();
    build_model(key);
    secret_key = key;
    stall_viol = 0;
  endtask

  function automatic int get_log(input int idx);
    if (idx < log_q.size()) return log_q[idx];
    return -1;
  endfunction

  // Next posedge accepts the start; then count edges until finish_ksa.
  task automatic wait_done(input int exp_cycles, input string name);
    int  cyc;
    bit  done;
    int  bad;
    int  seen [256];
    cyc  = 0;
    done = 1'b0;
    @(posedge clk);
    #1 secret_key = 24'($urandom);   // mid-run key changes must be ignored
    while (!done && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (finish_ksa) done = 1'b1;
    end
    check({name, "_latency"}, cyc, exp_cycles);
    @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(s_mem[k]) != model_s[k]) bad++;
    check({name, "_final_s_bad_bytes"}, bad, 0);
    for (int k = 0; k < 256; k++) seen[k] = 0;
    for (int k = 0; k < 256; k++) seen[s_mem[k]]++;
    bad = 0;
    for (int k = 0; k < 256; k++) if (seen[k] != 1) bad++;
    check({name, "_permutation_bad"}, bad, 0);
    check({name, "_stall_unstable"}, stall_viol, 0);
  endtask

  task automatic drop_start(input string name);
    @(negedge clk) start_ksa = 1'b0;
    @(posedge clk);
    #1 check({name, "_finish_after_drop"}, int'(finish_ksa), 0);
  endtask

  int seq0 [12] = '{32'h00000, 32'h00000, 32'h10000, 32'h10000,
                    32'h00100, 32'h00100, 32'h10101, 32'h10101,
                    32'h00200, 32'h00300, 32'h10203, 32'h10302};
  int seq3c [8] = '{32'h00100, 32'h00400, 32'h10104, 32'h10401,
                    32'h00200, 32'h04200, 32'h10242, 32'h14202};

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [23:0] key;
    int          guard;

    reset      = 1'b0;
    start_ksa  = 1'b0;
    secret_key = '0;
    #1;
    check("rst_finish_ksa", int'(finish_ksa), 0);
    check("rst_start_op",   int'(start_op),   0);
    check("rst_readWrite",  int'(readWrite),  0);
    check("rst_address",    int'(address),    0);
    check("rst_data_out",   int'(data_out),   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Zero key, identity S, memory never stalls.
    prep(24'h000000);
    start_ksa = 1'b1;
    wait_done(1024, "key0");
    for (int n = 0; n < 12; n++) check($sformatf("key0_seq_%0d", n), get_log(n), seq0[n]);
    // Held start after completion: no retrigger, no further accesses.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("hold_done", int'({finish_ksa, start_op}), 2);
    end
    drop_start("key0");

    // Known key with documented early iterations.
    prep(24'h00033C);
    start_ksa = 1'b1;
    wait_done(1024, "key33c");
    for (int n = 0; n < 8; n++) check($sformatf("key33c_seq_%0d", n + 4), get_log(n + 4), seq3c[n]);
    drop_start("key33c");

    // Every access stalls for 3 cycles.
    stall_mode = 1'b1;
    prep(24'($urandom));
    start_ksa = 1'b1;
    wait_done(4096, "stall");
    drop_start("stall");
    stall_mode = 1'b0;

    // Random keys.
    for (int r = 0; r < 3; r++) begin
      key = 24'($urandom);
      prep(key);
      start_ksa = 1'b1;
      wait_done(1024, $sformatf("rand%0d", r));
      drop_start($sformatf("rand%0d", r));
    end

    // Abort at i=0x80 with an asynchronous reset, then restart.
    prep(24'($urandom));
    start_ksa = 1'b1;
    guard = 0;
    while (log_q.size() < 512 && guard < 5000) begin
      @(negedge clk);
      #1 guard++;
    end
    check("abort_reached", int'(log_q.size() >= 512), 1);
    @(posedge clk);
    #1 check("pre_abort_access", pack(int'(readWrite), int'(address), 0), 32'h08000);
    #2 reset = 1'b0;
    #1;
    check("abort_start_op",  int'(start_op),  0);
    check("abort_address",   int'(address),   0);
    check("abort_readWrite", int'(readWrite), 0);
    check("abort_data_out",  int'(data_out),  0);
    check("abort_finish",    int'(finish_ksa), 0);
    repeat (2) @(negedge clk);
    prep(24'($urandom));
    reset = 1'b1;
    wait_done(1024, "restart");
    check("restart_first_access", get_log(0), 0);
    drop_start("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
